// File: rtl/wb_write_port_arbiter_if.sv
// Pipeline-to-writeback bundle: ALU results, MDU issue/result handshake,
// register-file write port and ID-stage hazard query.
interface wb_write_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_wr_valid;
  logic [ADDR_W-1:0] alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              mdu_req_valid;
  logic [ADDR_W-1:0] mdu_req_addr;
  logic              mdu_wb_valid;
  logic              mdu_wb_ready;
  logic [ADDR_W-1:0] mdu_wb_addr;
  logic [DATA_W-1:0] mdu_wb_data;
  logic              rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              hazard_stall;

  modport master (
    output alu_wr_valid, alu_wr_addr, alu_wr_data,
    output mdu_req_valid, mdu_req_addr,
    output mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
    input  mdu_wb_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data,
    output rs, rt,
    input  hazard_stall
  );

  modport slave (
    input  alu_wr_valid, alu_wr_addr, alu_wr_data,
    input  mdu_req_valid, mdu_req_addr,
    input  mdu_wb_valid, mdu_wb_addr, mdu_wb_data,
    output mdu_wb_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data,
    input  rs, rt,
    output hazard_stall
  );
endinterface

// File: rtl/wb_write_port_arbiter.sv
// Register-file write port owner: ALU results win, buffered MDU results drain
// when the ALU is idle, and a pending-write scoreboard drives the ID hazard stall.
module wb_write_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  wb_write_port_arbiter_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          idle_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              rf_wr_en_q;
  logic [ADDR_W-1:0] rf_wr_addr_q;
  logic [DATA_W-1:0] rf_wr_data_q;

  logic              ready;
  logic              push;
  logic              pop;
  logic              alu_wr;
  logic [ADDR_W-1:0] head_addr;

  assign ready     = !reset_i && (count_q < CNT_W'(FIFO_DEPTH));
  // Results for $0 complete the handshake but never occupy a slot.
  assign push      = bus.mdu_wb_valid && ready && (bus.mdu_wb_addr != '0);
  assign alu_wr    = bus.alu_wr_valid && (bus.alu_wr_addr != '0);
  assign pop       = !alu_wr && (count_q != '0);
  assign head_addr = mem_addr_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A new issue to a register outranks retirement of its older result.
  assign pending_d[0] = 1'b0;
  for (genvar gi = 1; gi < NREG; gi++) begin : g_pending
    assign pending_d[gi] = (bus.mdu_req_valid && (bus.mdu_req_addr == ADDR_W'(gi))) ||
                           (pending_q[gi] && !(pop && (head_addr == ADDR_W'(gi))));
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.mdu_wb_data;
      mem_addr_q[wr_ptr_q] <= bus.mdu_wb_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (alu_wr) begin
        rf_wr_en_q   <= 1'b1;
        rf_wr_addr_q <= bus.alu_wr_addr;
        rf_wr_data_q <= bus.alu_wr_data;
      end else if (pop) begin
        rf_wr_en_q   <= 1'b1;
        rf_wr_addr_q <= head_addr;
        rf_wr_data_q <= mem_data_q[rd_ptr_q];
      end else begin
        rf_wr_en_q   <= 1'b0;
      end
    end
  end

  assign bus.mdu_wb_ready = ready;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_wr_addr   = rf_wr_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.hazard_stall = !reset_i && (pending_q[bus.rs] || pending_q[bus.rt]);
  assign fifo_count_o     = count_q;
  assign idle_o           = (count_q == '0) && (pending_q == '0);
endmodule

// File: tb/tb_wb_write_port_arbiter.sv
// Directed bench: expected register-file writes go into a queue that a
// negedge monitor drains; state outputs are checked inline after each edge.
module tb_wb_write_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic reset;
  logic [$clog2(D):0] fifo_count;
  logic idle;

  wb_write_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_write_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (bus),
    .fifo_count_o (fifo_count),
    .idle_o       (idle)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [AW+DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_wr_valid  = 1'b0;
    bus.alu_wr_addr   = '0;
    bus.alu_wr_data   = '0;
    bus.mdu_req_valid = 1'b0;
    bus.mdu_req_addr  = '0;
    bus.mdu_wb_valid  = 1'b0;
    bus.mdu_wb_addr   = '0;
    bus.mdu_wb_data   = '0;
    bus.rs            = '0;
    bus.rt            = '0;
  endtask

  task automatic alu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.alu_wr_valid = 1'b1;
    bus.alu_wr_addr  = a;
    bus.alu_wr_data  = d;
    if (a != '0) exp_q.push_back({a, d});
  endtask

  task automatic mdu_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.mdu_wb_valid = 1'b1;
    bus.mdu_wb_addr  = a;
    bus.mdu_wb_data  = d;
  endtask

  // Monitor: every write the port presents must match the next expected one.
  always @(negedge clk) begin
    if (bus.rf_wr_en === 1'b1) begin
      $display("wr r%0d = %08h", bus.rf_wr_addr, bus.rf_wr_data);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, bus.rf_wr_addr, bus.rf_wr_data}, 64'd0);
      end else begin
        chk("rf_write", {27'd0, bus.rf_wr_addr, bus.rf_wr_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("ready_in_reset", bus.mdu_wb_ready, 0);
    step();
    step();
    chk("rst_wr_en", bus.rf_wr_en, 0);
    chk("rst_wr_addr", bus.rf_wr_addr, 0);
    chk("rst_wr_data", bus.rf_wr_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_idle", idle, 1);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", bus.mdu_wb_ready, 1);

    // T1: reset while FIFO holds three entries and r20 is pending
    bus.mdu_req_valid = 1'b1; bus.mdu_req_addr = 5'd20;
    for (int i = 0; i < 3; i++) begin
      alu(5'd2, 32'h100 + i);
      mdu_wb(5'd20 + 5'(i), 32'h200 + i);
      step();
      bus.mdu_req_valid = 1'b0;
    end
    idle_inputs();
    bus.rs = 5'd20;
    #1;
    chk("t1_count3", fifo_count, 3);
    chk("t1_stall_pre", bus.hazard_stall, 1);
    reset = 1'b1;
    #1;
    chk("t1_ready_rst", bus.mdu_wb_ready, 0);
    chk("t1_stall_rst", bus.hazard_stall, 0);
    step();
    chk("t1_ready_rst2", bus.mdu_wb_ready, 0);
    step();
    reset = 1'b0;
    #1;
    chk("t1_count0", fifo_count, 0);
    chk("t1_wr_en0", bus.rf_wr_en, 0);
    chk("t1_stall_post", bus.hazard_stall, 0);
    chk("t1_idle", idle, 1);
    step();
    chk("t1_no_write", bus.rf_wr_en, 0);
    idle_inputs();

    // T2: ALU path, then ALU write to $0 is dropped
    alu(5'd5, 32'hDEADBEEF);
    step();
    chk("t2_wr_en", bus.rf_wr_en, 1);
    chk("t2_wr_addr", bus.rf_wr_addr, 5);
    chk("t2_wr_data", bus.rf_wr_data, 32'hDEADBEEF);
    alu(5'd0, 32'h12345678);
    step();
    chk("t2_r0_en", bus.rf_wr_en, 0);
    chk("t2_hold_addr", bus.rf_wr_addr, 5);
    chk("t2_hold_data", bus.rf_wr_data, 32'hDEADBEEF);
    idle_inputs();

    // T3: ALU priority over a buffered r8
    mdu_wb(5'd8, 32'h11);
    for (int i = 0; i < 3; i++) begin
      alu(5'd9, 32'h22);
      step();
      bus.mdu_wb_valid = 1'b0;
      chk("t3_count1", fifo_count, 1);
    end
    idle_inputs();
    exp_q.push_back({5'd8, 32'h11});
    step();
    chk("t3_count0", fifo_count, 0);
    chk("t3_drain_en", bus.rf_wr_en, 1);

    // T4: fill to depth under ALU traffic, stalled fifth offer, in-order drain
    for (int i = 0; i < 4; i++) begin
      alu(5'd1, 32'h300 + i);
      mdu_wb(5'd11 + 5'(i), 32'hA0 + i);
      step();
      chk("t4_fill_count", fifo_count, 64'(i + 1));
    end
    chk("t4_ready_full", bus.mdu_wb_ready, 0);
    alu(5'd1, 32'h304);
    mdu_wb(5'd15, 32'hA4);
    step();
    chk("t4_5th_stalled", fifo_count, 4);
    chk("t4_ready_still0", bus.mdu_wb_ready, 0);
    bus.alu_wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back({5'd11 + 5'(i), 32'hA0 + i});
    step();
    chk("t4_count_pop1", fifo_count, 3);
    chk("t4_ready_rise", bus.mdu_wb_ready, 1);
    step();
    bus.mdu_wb_valid = 1'b0;
    chk("t4_push_pop", fifo_count, 3);
    step(); step(); step();
    chk("t4_drained", fifo_count, 0);
    idle_inputs();

    // T5: scoreboard set, ALU write keeps it, MDU retire clears, set beats clear
    bus.mdu_req_valid = 1'b1; bus.mdu_req_addr = 5'd10; bus.rs = 5'd10;
    step();
    bus.mdu_req_valid = 1'b0;
    chk("t5_stall_rs", bus.hazard_stall, 1);
    chk("t5_not_idle", idle, 0);
    bus.rs = 5'd0; bus.rt = 5'd10;
    alu(5'd10, 32'h99);
    step();
    bus.alu_wr_valid = 1'b0;
    chk("t5_stall_after_alu", bus.hazard_stall, 1);
    mdu_wb(5'd10, 32'h5A);
    exp_q.push_back({5'd10, 32'h5A});
    step();
    bus.mdu_wb_valid = 1'b0;
    chk("t5_count1", fifo_count, 1);
    chk("t5_stall_N", bus.hazard_stall, 1);
    chk("t5_no_bypass", bus.rf_wr_en, 0);
    step();
    chk("t5_wr_N1", bus.rf_wr_en, 1);
    chk("t5_stall_drop", bus.hazard_stall, 0);
    chk("t5_idle", idle, 1);
    bus.mdu_req_valid = 1'b1; bus.mdu_req_addr = 5'd10;
    step();
    bus.mdu_req_valid = 1'b0;
    mdu_wb(5'd10, 32'h77);
    exp_q.push_back({5'd10, 32'h77});
    step();
    bus.mdu_wb_valid = 1'b0;
    bus.mdu_req_valid = 1'b1;
    step();
    bus.mdu_req_valid = 1'b0;
    chk("t5_retire_en", bus.rf_wr_en, 1);
    chk("t5_set_wins", bus.hazard_stall, 1);
    mdu_wb(5'd10, 32'h78);
    exp_q.push_back({5'd10, 32'h78});
    step();
    bus.mdu_wb_valid = 1'b0;
    step();
    chk("t5_final_stall", bus.hazard_stall, 0);
    chk("t5_final_idle", idle, 1);
    idle_inputs();

    // T6: $0 never pending or buffered; FIFO drains past an ALU $0 write
    bus.mdu_req_valid = 1'b1; bus.mdu_req_addr = 5'd0;
    mdu_wb(5'd0, 32'hFF);
    #1;
    chk("t6_ready_r0", bus.mdu_wb_ready, 1);
    step();
    idle_inputs();
    chk("t6_count0", fifo_count, 0);
    chk("t6_idle", idle, 1);
    chk("t6_stall0", bus.hazard_stall, 0);
    step();
    chk("t6_no_write", bus.rf_wr_en, 0);
    mdu_wb(5'd3, 32'h33);
    alu(5'd0, 32'h44);
    step();
    bus.mdu_wb_valid = 1'b0;
    chk("t6_count1", fifo_count, 1);
    chk("t6_r0_no_write", bus.rf_wr_en, 0);
    exp_q.push_back({5'd3, 32'h33});
    step();
    chk("t6_drain_en", bus.rf_wr_en, 1);
    chk("t6_drain_count", fifo_count, 0);
    idle_inputs();

    step();
    step();
    chk("exp_queue_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
